// File: rtl/memory_access_stage.sv
// RV64 MEM stage: loads/stores through a valid/ready dcache port,
// fixed 2-cycle pass-through for non-memory instructions.
package memory_access_pkg;
   typedef struct packed {
      logic [6:0]  opcode;
      logic [31:0] instruction;
      logic [63:0] pc;
   } control_signals_struct;
endpackage

module memory_access_stage
   import memory_access_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  memory_enable,
   input  logic [63:0]           alu_data_in,
   input  logic [63:0]           reg_b_contents,
   input  control_signals_struct control_signals,
   output logic                  dcache_req_valid,
   input  logic                  dcache_req_ready,
   output logic [ADDR_WIDTH-1:0] dcache_req_addr,
   output logic                  dcache_req_write,
   output logic [DATA_WIDTH-1:0] dcache_req_wdata,
   output logic [7:0]            dcache_req_wstrb,
   input  logic                  dcache_resp_valid,
   input  logic [DATA_WIDTH-1:0] dcache_resp_rdata,
   output logic [63:0]           wb_data_out,
   output control_signals_struct control_signals_out,
   output logic                  misaligned_out,
   output logic                  memory_busy,
   output logic                  memory_done
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

   state_t                state_q, state_d;
   logic [63:0]           addr_q, addr_d;
   logic [63:0]           rs2_q, rs2_d;
   control_signals_struct ctrl_q, ctrl_d;
   logic [63:0]           wb_q, wb_d;
   logic                  mis_q, mis_d;
   control_signals_struct ctrl_out_q, ctrl_out_d;

   logic [2:0]  in_f3, q_f3;
   logic        in_load, in_store, in_mem;
   logic        in_aligned, in_illegal, in_mis;
   logic        q_store, is_req;
   logic [5:0]  sh;
   logic [63:0] r, load_val;
   logic [7:0]  strb_base;

   assign in_f3    = control_signals.instruction[14:12];
   assign in_load  = control_signals.opcode == OP_LOAD;
   assign in_store = control_signals.opcode == OP_STORE;
   assign in_mem   = in_load | in_store;

   always_comb begin
      in_aligned = 1'b1;
      unique case (in_f3[1:0])
         2'b00: in_aligned = 1'b1;
         2'b01: in_aligned = ~alu_data_in[0];
         2'b10: in_aligned = alu_data_in[1:0] == 2'b00;
         2'b11: in_aligned = alu_data_in[2:0] == 3'b000;
      endcase
   end

   // loads have unsigned variants; stores only use funct3 000..011
   assign in_illegal = in_load ? (in_f3 == 3'b111) : in_f3[2];
   assign in_mis     = in_mem & (~in_aligned | in_illegal);

   assign q_f3    = ctrl_q.instruction[14:12];
   assign q_store = ctrl_q.opcode == OP_STORE;
   assign sh      = {addr_q[2:0], 3'b000};
   assign r       = dcache_resp_rdata >> sh;
   assign is_req  = state_q == REQ;

   always_comb begin
      load_val = r;
      unique case (q_f3)
         3'b000:  load_val = {{56{r[7]}}, r[7:0]};
         3'b001:  load_val = {{48{r[15]}}, r[15:0]};
         3'b010:  load_val = {{32{r[31]}}, r[31:0]};
         3'b011:  load_val = r;
         3'b100:  load_val = {56'b0, r[7:0]};
         3'b101:  load_val = {48'b0, r[15:0]};
         3'b110:  load_val = {32'b0, r[31:0]};
         default: load_val = 64'b0;
      endcase
   end

   always_comb begin
      strb_base = 8'h00;
      unique case (q_f3[1:0])
         2'b00: strb_base = 8'h01;
         2'b01: strb_base = 8'h03;
         2'b10: strb_base = 8'h0F;
         2'b11: strb_base = 8'hFF;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rs2_d      = rs2_q;
      ctrl_d     = ctrl_q;
      wb_d       = wb_q;
      mis_d      = mis_q;
      ctrl_out_d = ctrl_out_q;
      unique case (state_q)
         IDLE: begin
            if (memory_enable) begin
               addr_d = alu_data_in;
               rs2_d  = reg_b_contents;
               ctrl_d = control_signals;
               if (in_mem && !in_mis) begin
                  state_d = REQ;
               end else begin
                  state_d    = DONE;
                  mis_d      = in_mis;
                  ctrl_out_d = control_signals;
                  if (in_mem)
                     wb_d = 64'b0;
                  else if (control_signals.opcode == OP_JAL ||
                           control_signals.opcode == OP_JALR)
                     wb_d = control_signals.pc + 64'd4;
                  else
                     wb_d = alu_data_in;
               end
            end
         end
         REQ: begin
            if (dcache_req_ready) state_d = WAIT_RESP;
         end
         WAIT_RESP: begin
            if (dcache_resp_valid) begin
               state_d    = DONE;
               mis_d      = 1'b0;
               ctrl_out_d = ctrl_q;
               wb_d       = q_store ? 64'b0 : load_val;
            end
         end
         DONE: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rs2_q      <= '0;
         ctrl_q     <= '0;
         wb_q       <= '0;
         mis_q      <= 1'b0;
         ctrl_out_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rs2_q      <= rs2_d;
         ctrl_q     <= ctrl_d;
         wb_q       <= wb_d;
         mis_q      <= mis_d;
         ctrl_out_q <= ctrl_out_d;
      end
   end

   assign dcache_req_valid    = is_req;
   assign dcache_req_addr     = is_req ? {addr_q[ADDR_WIDTH-1:3], 3'b000} : '0;
   assign dcache_req_write    = is_req & q_store;
   assign dcache_req_wdata    = (is_req && q_store) ? rs2_q << sh : '0;
   assign dcache_req_wstrb    = (is_req && q_store) ? strb_base << addr_q[2:0] : 8'h00;
   assign wb_data_out         = wb_q;
   assign misaligned_out      = mis_q;
   assign control_signals_out = ctrl_out_q;
   assign memory_busy         = state_q != IDLE;
   assign memory_done         = state_q == DONE;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed-vector bench for memory_access_stage.
module tb_memory_access_stage;
   import memory_access_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  memory_enable;
   logic [63:0]           alu_data_in;
   logic [63:0]           reg_b_contents;
   control_signals_struct control_signals;
   logic                  dcache_req_valid;
   logic                  dcache_req_ready;
   logic [63:0]           dcache_req_addr;
   logic                  dcache_req_write;
   logic [63:0]           dcache_req_wdata;
   logic [7:0]            dcache_req_wstrb;
   logic                  dcache_resp_valid;
   logic [63:0]           dcache_resp_rdata;
   logic [63:0]           wb_data_out;
   control_signals_struct control_signals_out;
   logic                  misaligned_out;
   logic                  memory_busy;
   logic                  memory_done;

   int n_vec = 0;
   int n_err = 0;

   memory_access_stage dut (
      .clk                 (clk),
      .reset               (reset),
      .memory_enable       (memory_enable),
      .alu_data_in         (alu_data_in),
      .reg_b_contents      (reg_b_contents),
      .control_signals     (control_signals),
      .dcache_req_valid    (dcache_req_valid),
      .dcache_req_ready    (dcache_req_ready),
      .dcache_req_addr     (dcache_req_addr),
      .dcache_req_write    (dcache_req_write),
      .dcache_req_wdata    (dcache_req_wdata),
      .dcache_req_wstrb    (dcache_req_wstrb),
      .dcache_resp_valid   (dcache_resp_valid),
      .dcache_resp_rdata   (dcache_resp_rdata),
      .wb_data_out         (wb_data_out),
      .control_signals_out (control_signals_out),
      .misaligned_out      (misaligned_out),
      .memory_busy         (memory_busy),
      .memory_done         (memory_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [6:0] op, input logic [2:0] f3,
                         input logic [63:0] pc, input logic [63:0] a,
                         input logic [63:0] b);
      control_signals.opcode      = op;
      control_signals.instruction = {17'b0, f3, 5'b0, op};
      control_signals.pc          = pc;
      alu_data_in                 = a;
      reg_b_contents              = b;
   endtask

   task automatic run_load(input string tag, input logic [63:0] a,
                           input logic [2:0] f3, input logic [63:0] rd,
                           input logic [63:0] exp);
      set_op(7'b0000011, f3, 64'h100, a, 64'h0);
      dcache_req_ready = 1'b1;
      memory_enable = 1'b1;
      tick();
      memory_enable = 1'b0;
      chk({tag, "_valid"}, {63'b0, dcache_req_valid}, 64'd1);
      chk({tag, "_addr"}, dcache_req_addr, {a[63:3], 3'b000});
      tick();
      dcache_resp_valid = 1'b1;
      dcache_resp_rdata = rd;
      tick();
      dcache_resp_valid = 1'b0;
      chk({tag, "_done"}, {63'b0, memory_done}, 64'd1);
      chk({tag, "_wb"}, wb_data_out, exp);
      tick();
   endtask

   task automatic run_store(input string tag, input logic [63:0] a,
                            input logic [2:0] f3, input logic [63:0] b,
                            input logic [63:0] exp_wd,
                            input logic [7:0] exp_st);
      set_op(7'b0100011, f3, 64'h200, a, b);
      dcache_req_ready = 1'b1;
      memory_enable = 1'b1;
      tick();
      memory_enable = 1'b0;
      chk({tag, "_wdata"}, dcache_req_wdata, exp_wd);
      chk({tag, "_wstrb"}, {56'b0, dcache_req_wstrb}, {56'b0, exp_st});
      tick();
      dcache_resp_valid = 1'b1;
      tick();
      dcache_resp_valid = 1'b0;
      chk({tag, "_done"}, {63'b0, memory_done}, 64'd1);
      chk({tag, "_wb"}, wb_data_out, 64'd0);
      tick();
   endtask

   initial begin
      reset = 1'b1;
      memory_enable = 1'b0;
      dcache_req_ready = 1'b0;
      dcache_resp_valid = 1'b0;
      dcache_resp_rdata = 64'h0;
      set_op(7'b0, 3'b0, 64'h0, 64'h0, 64'h0);
      tick();
      tick();
      chk("rst_valid", {63'b0, dcache_req_valid}, 64'd0);
      chk("rst_done", {63'b0, memory_done}, 64'd0);
      chk("rst_busy", {63'b0, memory_busy}, 64'd0);
      chk("rst_wb", wb_data_out, 64'd0);
      chk("rst_pc", control_signals_out.pc, 64'd0);
      reset = 1'b0;
      tick();

      // ALU pass-through
      set_op(7'b0110011, 3'b000, 64'h40, 64'h1234, 64'h0);
      memory_enable = 1'b1;
      tick();
      memory_enable = 1'b0;
      chk("alu_done", {63'b0, memory_done}, 64'd1);
      chk("alu_valid", {63'b0, dcache_req_valid}, 64'd0);
      chk("alu_wb", wb_data_out, 64'h1234);
      tick();
      chk("alu_done_off", {63'b0, memory_done}, 64'd0);
      chk("alu_idle", {63'b0, memory_busy}, 64'd0);

      // LB sign, best case
      set_op(7'b0000011, 3'b000, 64'h50, 64'h1003, 64'h0);
      dcache_req_ready = 1'b1;
      memory_enable = 1'b1;
      tick();
      memory_enable = 1'b0;
      chk("lb_valid", {63'b0, dcache_req_valid}, 64'd1);
      chk("lb_addr", dcache_req_addr, 64'h1000);
      chk("lb_write", {63'b0, dcache_req_write}, 64'd0);
      chk("lb_wstrb", {56'b0, dcache_req_wstrb}, 64'd0);
      tick();
      chk("lb_valid_drop", {63'b0, dcache_req_valid}, 64'd0);
      chk("lb_no_done2", {63'b0, memory_done}, 64'd0);
      dcache_resp_valid = 1'b1;
      dcache_resp_rdata = 64'h0000_0000_8000_0000;
      tick();
      dcache_resp_valid = 1'b0;
      chk("lb_done3", {63'b0, memory_done}, 64'd1);
      chk("lb_wb", wb_data_out, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_pc_out", control_signals_out.pc, 64'h50);
      tick();

      // SH with ready stalled 3 cycles
      set_op(7'b0100011, 3'b001, 64'h60, 64'h2006, 64'hABCD);
      dcache_req_ready = 1'b0;
      memory_enable = 1'b1;
      tick();
      memory_enable = 1'b0;
      chk("sh_wdata", dcache_req_wdata, 64'hABCD_0000_0000_0000);
      chk("sh_wstrb", {56'b0, dcache_req_wstrb}, 64'hC0);
      chk("sh_write", {63'b0, dcache_req_write}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         chk("sh_stall_valid", {63'b0, dcache_req_valid}, 64'd1);
         chk("sh_stall_addr", dcache_req_addr, 64'h2000);
         chk("sh_stall_done", {63'b0, memory_done}, 64'd0);
         if (i == 2) dcache_req_ready = 1'b1;
         tick();
      end
      dcache_req_ready = 1'b0;
      chk("sh_valid_drop", {63'b0, dcache_req_valid}, 64'd0);
      chk("sh_wait_done", {63'b0, memory_done}, 64'd0);
      dcache_resp_valid = 1'b1;
      tick();
      dcache_resp_valid = 1'b0;
      chk("sh_done6", {63'b0, memory_done}, 64'd1);
      chk("sh_wb", wb_data_out, 64'd0);
      tick();

      // misaligned LW
      set_op(7'b0000011, 3'b010, 64'h70, 64'h3002, 64'h0);
      memory_enable = 1'b1;
      tick();
      memory_enable = 1'b0;
      chk("mis_done", {63'b0, memory_done}, 64'd1);
      chk("mis_flag", {63'b0, misaligned_out}, 64'd1);
      chk("mis_wb", wb_data_out, 64'd0);
      chk("mis_valid", {63'b0, dcache_req_valid}, 64'd0);
      tick();
      chk("mis_valid2", {63'b0, dcache_req_valid}, 64'd0);

      // enable while busy is ignored
      set_op(7'b0000011, 3'b011, 64'h90, 64'h4000, 64'h0);
      dcache_req_ready = 1'b0;
      memory_enable = 1'b1;
      tick();
      set_op(7'b1101111, 3'b000, 64'hDEAD_0000, 64'h0, 64'h0);
      tick();
      memory_enable = 1'b0;
      chk("busy_valid", {63'b0, dcache_req_valid}, 64'd1);
      chk("busy_addr", dcache_req_addr, 64'h4000);
      dcache_req_ready = 1'b1;
      tick();
      dcache_req_ready = 1'b0;
      dcache_resp_valid = 1'b1;
      dcache_resp_rdata = 64'h1122_3344_5566_7788;
      tick();
      dcache_resp_valid = 1'b0;
      chk("ld_done", {63'b0, memory_done}, 64'd1);
      chk("ld_wb", wb_data_out, 64'h1122_3344_5566_7788);
      chk("ld_mis_clr", {63'b0, misaligned_out}, 64'd0);
      chk("ld_pc_out", control_signals_out.pc, 64'h90);
      tick();
      chk("ld_idle", {63'b0, memory_busy}, 64'd0);

      // JAL / JALR link values
      set_op(7'b1101111, 3'b000, 64'h8000_0000, 64'h5555, 64'h0);
      memory_enable = 1'b1;
      tick();
      memory_enable = 1'b0;
      chk("jal_done", {63'b0, memory_done}, 64'd1);
      chk("jal_wb", wb_data_out, 64'h8000_0004);
      tick();
      set_op(7'b1100111, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h7, 64'h0);
      memory_enable = 1'b1;
      tick();
      memory_enable = 1'b0;
      chk("jalr_wrap_wb", wb_data_out, 64'h0);
      tick();

      run_load("lhu", 64'h5002, 3'b101, 64'h0000_0000_F00D_0000, 64'hF00D);
      run_load("lw", 64'h5004, 3'b010, 64'h8765_4321_0000_0000,
               64'hFFFF_FFFF_8765_4321);
      run_load("lbu", 64'h5007, 3'b100, 64'hF100_0000_0000_0000, 64'hF1);
      run_store("sd", 64'h6000, 3'b011, 64'h0123_4567_89AB_CDEF,
                64'h0123_4567_89AB_CDEF, 8'hFF);
      run_store("sb", 64'h6007, 3'b000, 64'h5A,
                64'h5A00_0000_0000_0000, 8'h80);
      run_store("sw", 64'h6004, 3'b010, 64'hCAFE_BABE,
                64'hCAFE_BABE_0000_0000, 8'hF0);

      // funct3 111 load is dropped
      set_op(7'b0000011, 3'b111, 64'hA0, 64'h7000, 64'h0);
      memory_enable = 1'b1;
      tick();
      memory_enable = 1'b0;
      chk("f3_111_mis", {63'b0, misaligned_out}, 64'd1);
      chk("f3_111_valid", {63'b0, dcache_req_valid}, 64'd0);
      tick();

      // reset in WAIT_RESP, late response ignored
      set_op(7'b0000011, 3'b000, 64'hB0, 64'h1003, 64'h0);
      dcache_req_ready = 1'b1;
      memory_enable = 1'b1;
      tick();
      memory_enable = 1'b0;
      tick();
      dcache_req_ready = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      dcache_resp_valid = 1'b1;
      dcache_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      chk("mrst_valid", {63'b0, dcache_req_valid}, 64'd0);
      chk("mrst_busy", {63'b0, memory_busy}, 64'd0);
      chk("mrst_wb", wb_data_out, 64'd0);
      chk("mrst_mis", {63'b0, misaligned_out}, 64'd0);
      chk("mrst_pc", control_signals_out.pc, 64'd0);
      tick();
      dcache_resp_valid = 1'b0;
      chk("late_resp_done", {63'b0, memory_done}, 64'd0);
      chk("late_resp_busy", {63'b0, memory_busy}, 64'd0);
      chk("late_resp_wb", wb_data_out, 64'd0);
      tick();
      chk("late_resp_done2", {63'b0, memory_done}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
